// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: next-PC select encodings, exception
// vectors, and the kernel-preserving PC increment.
package mips_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned JT_W   = 26;
    localparam int unsigned PCSRC_W = 3;

    typedef enum logic [PCSRC_W-1:0] {
        PCSRC_SEQ    = 3'd0,
        PCSRC_BRANCH = 3'd1,
        PCSRC_JUMP   = 3'd2,
        PCSRC_JR     = 3'd3,
        PCSRC_IRQ    = 3'd4,
        PCSRC_ILLOP  = 3'd5
    } pcsrc_e;

    localparam logic [XLEN-1:0] VEC_RESET = 32'h8000_0000;
    localparam logic [XLEN-1:0] VEC_IRQ   = 32'h8000_0004;
    localparam logic [XLEN-1:0] VEC_ILLOP = 32'h8000_0008;

    // Bit 31 is the kernel flag: the increment never carries into it.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1], 31'(pc[XLEN-2:0] + 31'd4)};
    endfunction

endpackage

// File: rtl/pipeline_pc_sel.sv
// Combinational next-PC selection: target mux plus stall/exception/branch/jump priority.
// IRQ redirect is enabled only when IRQ_EN is defined.
module pipeline_pc_sel
    import mips_pkg::*;
(
    input  logic [XLEN-1:0]    i_pc,
    input  logic [XLEN-1:0]    i_pc_plus4,
    input  logic [3:0]         i_id_pc_hi,
    input  logic [PCSRC_W-1:0] i_pcsrc,
    input  logic               i_branch,
    input  logic               i_jump,
    input  logic [XLEN-1:0]    i_conba,
    input  logic [JT_W-1:0]    i_jt,
    input  logic [XLEN-1:0]    i_jr_target,
    input  logic               i_stall,
    output logic [XLEN-1:0]    o_next_pc_c,
    output logic               o_redirect_c,
    output logic               o_hold_c
);

    logic w_irq;
    logic w_illop;

`ifdef IRQ_EN
    assign w_irq = (i_pcsrc == PCSRC_IRQ);
`else
    assign w_irq = 1'b0;
`endif
    assign w_illop = (i_pcsrc == PCSRC_ILLOP);

    // Stall wins outright; any redirect squashes the fetch currently in flight.
    always_comb begin
        o_next_pc_c  = i_pc_plus4;
        o_redirect_c = 1'b0;
        o_hold_c     = 1'b0;
        if (i_stall) begin
            o_next_pc_c = i_pc;
            o_hold_c    = 1'b1;
        end else if (w_illop) begin
            o_next_pc_c  = VEC_ILLOP;
            o_redirect_c = 1'b1;
        end else if (w_irq) begin
            o_next_pc_c  = VEC_IRQ;
            o_redirect_c = 1'b1;
        end else if (i_branch) begin
            o_next_pc_c  = i_conba;
            o_redirect_c = 1'b1;
        end else if (i_jump) begin
            o_redirect_c = 1'b1;
            if (i_pcsrc == PCSRC_JR) begin
                o_next_pc_c = i_jr_target;
            end else begin
                o_next_pc_c = {i_id_pc_hi, i_jt, 2'b00};
            end
        end
    end

endmodule

// File: rtl/pipeline_if.sv
// Instruction fetch stage: PC register and IF/ID pipeline register.
// Define IRQ_EN to let PCSrc=4 redirect to the IRQ vector.
module pipeline_if
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [PCSRC_W-1:0] PCSrc,
    input  logic               IDcontrol_Branch,
    input  logic               IDcontrol_Jump,
    input  logic [XLEN-1:0]    ConBA,
    input  logic [JT_W-1:0]    JT,
    input  logic [XLEN-1:0]    JR_target,
    input  logic               Stall,
    output logic [XLEN-1:0]    IM_addr,
    input  logic [XLEN-1:0]    IM_data,
    output logic [XLEN-1:0]    ID_PC,
    output logic [XLEN-1:0]    ID_instruction,
    output logic               ID_valid
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_id_pc;
    logic [XLEN-1:0] r_id_instr;
    logic            r_id_valid;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_next_pc;
    logic            w_redirect;
    logic            w_hold;

    assign w_pc_plus4 = pc_plus4(r_pc);

    pipeline_pc_sel u_pc_sel (
        .i_pc         (r_pc),
        .i_pc_plus4   (w_pc_plus4),
        .i_id_pc_hi   (r_id_pc[XLEN-1:XLEN-4]),
        .i_pcsrc      (PCSrc),
        .i_branch     (IDcontrol_Branch),
        .i_jump       (IDcontrol_Jump),
        .i_conba      (ConBA),
        .i_jt         (JT),
        .i_jr_target  (JR_target),
        .i_stall      (Stall),
        .o_next_pc_c  (w_next_pc),
        .o_redirect_c (w_redirect),
        .o_hold_c     (w_hold)
    );

    // ID_PC tracks PC+4 of the fetch even when it is squashed into a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= VEC_RESET;
            r_id_pc    <= '0;
            r_id_instr <= '0;
            r_id_valid <= 1'b0;
        end else if (!w_hold) begin
            r_pc    <= w_next_pc;
            r_id_pc <= w_pc_plus4;
            if (w_redirect) begin
                r_id_instr <= '0;
                r_id_valid <= 1'b0;
            end else begin
                r_id_instr <= IM_data;
                r_id_valid <= 1'b1;
            end
        end
    end

    assign IM_addr        = r_pc;
    assign ID_PC          = r_id_pc;
    assign ID_instruction = r_id_instr;
    assign ID_valid       = r_id_valid;

endmodule

// File: tb/tb_pipeline_if.sv
// Scoreboard bench for pipeline_if: a reference model pushes expected IF/ID state
// per edge, which is popped and compared after the edge.
module tb_pipeline_if;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] id_pc;
        logic [31:0] instr;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  PCSrc;
    logic        IDcontrol_Branch;
    logic        IDcontrol_Jump;
    logic [31:0] ConBA;
    logic [25:0] JT;
    logic [31:0] JR_target;
    logic        Stall;
    logic [31:0] IM_addr;
    logic [31:0] IM_data;
    logic [31:0] ID_PC;
    logic [31:0] ID_instruction;
    logic        ID_valid;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb[$];

    logic [31:0] m_pc, m_id_pc, m_id_instr;
    logic        m_id_valid;

    pipeline_if dut (
        .clk              (clk),
        .reset            (reset),
        .PCSrc            (PCSrc),
        .IDcontrol_Branch (IDcontrol_Branch),
        .IDcontrol_Jump   (IDcontrol_Jump),
        .ConBA            (ConBA),
        .JT               (JT),
        .JR_target        (JR_target),
        .Stall            (Stall),
        .IM_addr          (IM_addr),
        .IM_data          (IM_data),
        .ID_PC            (ID_PC),
        .ID_instruction   (ID_instruction),
        .ID_valid         (ID_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check_eq("pc", IM_addr, e.pc);
            check_eq("id_pc", ID_PC, e.id_pc);
            check_eq("id_instr", ID_instruction, e.instr);
            check_eq("id_valid", 32'(ID_valid), 32'(e.valid));
        end
    endtask

    // One clock: drive at negedge, model the edge, compare after it.
    task automatic step(input logic [2:0] src, input logic br, input logic jp, input logic st,
                        input logic [31:0] conba, input logic [25:0] jt,
                        input logic [31:0] jr, input logic [31:0] imd);
        logic [31:0] p4, tgt;
        logic        redir;
        @(negedge clk);
        reset = 1'b0;
        PCSrc = src; IDcontrol_Branch = br; IDcontrol_Jump = jp; Stall = st;
        ConBA = conba; JT = jt; JR_target = jr; IM_data = imd;
        #1;
        check_eq("im_addr", IM_addr, m_pc);
        p4 = {m_pc[31], m_pc[30:0] + 31'd4};
        if (!st) begin
            redir = 1'b1;
            if (src == 3'd5) tgt = 32'h8000_0008;
`ifdef IRQ_EN
            else if (src == 3'd4) tgt = 32'h8000_0004;
`endif
            else if (br) tgt = conba;
            else if (jp) tgt = (src == 3'd3) ? jr : {m_id_pc[31:28], jt, 2'b00};
            else begin
                redir = 1'b0;
                tgt = p4;
            end
            m_id_pc    = p4;
            m_id_instr = redir ? 32'h0 : imd;
            m_id_valid = ~redir;
            m_pc       = tgt;
        end
        sb.push_back('{m_pc, m_id_pc, m_id_instr, m_id_valid});
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    task automatic seq(input logic [31:0] imd);
        step(3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, imd);
    endtask

    task automatic branch_to(input logic [31:0] tgt);
        step(3'd1, 1'b1, 1'b0, 1'b0, tgt, 26'h0, 32'h0, $urandom);
    endtask

    // Async reset applied mid-cycle with the given stall/branch activity pending.
    task automatic do_reset(input logic st, input logic br);
        @(negedge clk);
        Stall = st; IDcontrol_Branch = br; PCSrc = 3'd1; ConBA = 32'h0000_1234;
        #2;
        reset = 1'b1;
        #1;
        m_pc = 32'h8000_0000; m_id_pc = 32'h0; m_id_instr = 32'h0; m_id_valid = 1'b0;
        check_eq("rst_pc", IM_addr, m_pc);
        check_eq("rst_id_pc", ID_PC, m_id_pc);
        check_eq("rst_id_instr", ID_instruction, m_id_instr);
        check_eq("rst_id_valid", 32'(ID_valid), 32'(m_id_valid));
        @(posedge clk);
        #1;
        check_eq("rst_hold_pc", IM_addr, 32'h8000_0000);
    endtask

    initial begin
        reset = 1'b1; PCSrc = 3'd0; IDcontrol_Branch = 1'b0; IDcontrol_Jump = 1'b0;
        ConBA = 32'h0; JT = 26'h0; JR_target = 32'h0; Stall = 1'b0; IM_data = 32'h0;
        do_reset(1'b0, 1'b0);

        seq(32'h3C01_0001);
        seq($urandom);
        seq($urandom);

        branch_to(32'h0000_000C);
        seq($urandom);
        step(3'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 26'h0, 32'h0, $urandom);
        seq($urandom);

        branch_to(32'h0040_0004);
        seq($urandom);
        step(3'd2, 1'b0, 1'b1, 1'b0, 32'h0, 26'h000_0100, 32'h0, $urandom);
        seq($urandom);

        step(3'd3, 1'b0, 1'b1, 1'b0, 32'h0, 26'h3FF_FFFF, 32'h1234_5678, $urandom);
        seq($urandom);

        step(3'd1, 1'b1, 1'b0, 1'b1, 32'h0000_0800, 26'h0, 32'h0, $urandom);
        step(3'd1, 1'b1, 1'b0, 1'b1, 32'h0000_0800, 26'h0, 32'h0, $urandom);
        step(3'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0800, 26'h0, 32'h0, $urandom);
        seq($urandom);

        step(3'd1, 1'b0, 1'b0, 1'b0, 32'h0000_4000, 26'h0, 32'h0, $urandom);
        step(3'd4, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, $urandom);
        seq($urandom);
        step(3'd5, 1'b1, 1'b1, 1'b0, 32'h0000_4000, 26'h10, 32'h0, $urandom);
        step(3'd2, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 26'h10, 32'h0, $urandom);
        step(3'd5, 1'b0, 1'b0, 1'b1, 32'h0, 26'h0, 32'h0, $urandom);

        branch_to(32'h7FFF_FFFC);
        seq($urandom);
        branch_to(32'hFFFF_FFFC);
        seq($urandom);
        seq($urandom);

        do_reset(1'b1, 1'b1);
        seq($urandom);
        seq($urandom);
        step(3'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 26'h0, 32'h0, $urandom);
        do_reset(1'b0, 1'b1);
        seq(32'hDEAD_BEEF);

        for (int i = 0; i < 60; i++) begin
            step(3'($urandom_range(0, 5)), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                 $urandom, 26'($urandom), $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_if.md
PIPELINE_IF -- requirements
Module: pipeline_IF

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port PCSrc  input  3  next-PC select from ID decode (0 seq, 1 branch, 2 J/JAL, 3 JR/JALR, 4 IRQ, 5 illegal-op).
REQ-004 SHALL have port IDcontrol_Branch  input  1  branch in ID resolved taken.
REQ-005 SHALL have port IDcontrol_Jump  input  1  jump (J/JAL/JR/JALR) in ID.
REQ-006 SHALL have port ConBA  input  32  branch target from ID.
REQ-007 SHALL have port JT  input  26  jump index from ID instruction.
REQ-008 SHALL have port JR_target  input  32  forwarded rs value for JR/JALR.
REQ-009 SHALL have port Stall  input  1  load-use hazard hold request.
REQ-010 SHALL have port IM_addr  output  32  instruction memory address (= PC).
REQ-011 SHALL have port IM_data  input  32  instruction word, combinational read of IM_addr.
REQ-012 SHALL have port ID_PC  output  32  registered PC+4 of instruction in ID.
REQ-013 SHALL have port ID_instruction  output  32  registered instruction in ID; 0 = bubble.
REQ-014 SHALL have port ID_valid  output  1  registered; 0 when ID slot is bubble.

Function
REQ-015 SHALL compute PC_plus4 = {PC[31], PC[30:0]+4}; bit 31 (kernel flag) never changes by increment; bits 30:0 wrap to 0 past 0x7FFFFFFC.
REQ-016 SHALL form jump target {ID_PC[31:28], JT, 2'b00}; branch target = ConBA; JR target = JR_target unchanged.
REQ-017 SHALL use vectors 0x80000000 (reset), 0x80000004 (IRQ), 0x80000008 (illegal-op).
REQ-018 SHALL apply priority per edge: Stall > exception (PCSrc 4/5) > IDcontrol_Branch > IDcontrol_Jump > sequential.
REQ-019 Stall=1: SHALL hold PC, ID_PC, ID_instruction, ID_valid; all redirects ignored that cycle (ID re-evaluates next cycle).
REQ-020 Redirect (exception, taken branch, jump): PC <= target; ID_instruction <= 0; ID_valid <= 0; ID_PC <= PC_plus4 of squashed fetch.
REQ-021 Sequential: PC <= PC_plus4; ID_instruction <= IM_data; ID_PC <= PC_plus4; ID_valid <= 1.
REQ-022 Branch not-taken (IDcontrol_Branch=0, PCSrc=1) SHALL behave as sequential; no flush.
REQ-023 Latency: redirect costs exactly one bubble; fetch-to-ID one cycle.
REQ-024 IM_addr SHALL equal PC combinationally.

Reset
REQ-025 reset=1 SHALL asynchronously force PC=0x80000000, ID_PC=0, ID_instruction=0, ID_valid=0.
REQ-026 Reset asserted mid-stall or mid-redirect SHALL override all; first edge after release fetches 0x80000000.

Configuration
REQ-027 With IRQ_EN defined: PCSrc=4 redirects to 0x80000004 per REQ-020.
REQ-028 Without IRQ_EN: PCSrc=4 treated as PCSrc=0; PCSrc=5 always active.

Structure
REQ-029 Shared package mips_pkg SHALL hold PCSrc encodings and the three vector constants.
REQ-030 Next-PC selection SHALL be one sub-module pipeline_pc_sel (combinational target mux + priority); registers stay in pipeline_IF.

Verification
REQ-031 Reset, release, IM_data=0x3C010001 -> after 1 edge ID_instruction=0x3C010001, ID_PC=0x80000004, PC=0x80000004.
REQ-032 ID_PC=0x00000010, ConBA=0x00000020, PCSrc=1, IDcontrol_Branch=1 -> PC=0x00000020, ID_instruction=0, ID_valid=0.
REQ-033 ID_PC=0x00400008, JT=0x0000100, PCSrc=2, IDcontrol_Jump=1 -> PC=0x00000400, one bubble.
REQ-034 Stall=1 with IDcontrol_Branch=1 for 2 cycles -> PC/ID regs unchanged both cycles; branch taken on cycle Stall drops.
REQ-035 PCSrc=4, IRQ_EN defined -> PC=0x80000004, bubble; undefined -> PC=PC_plus4, no bubble.
REQ-036 PC=0x7FFFFFFC sequential -> PC=0x00000000; PC=0xFFFFFFFC -> PC=0x80000000.
